// File: rtl/garage_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : garage_pkg
// Purpose  : Shared state encoding, priority encoding and defaults for the
//            garage gate arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package garage_pkg;

    localparam int DEF_CAPACITY     = 8;
    localparam int DEF_DOOR_CYCLES  = 4;
    localparam int DEF_GUARD_CYCLES = 2;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_ENTRY_OPEN = 2'd1;
    localparam logic [1:0] ST_EXIT_OPEN  = 2'd2;
    localparam logic [1:0] ST_GUARD      = 2'd3;

    localparam logic PRI_ENTRY = 1'b0;
    localparam logic PRI_EXIT  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/garage_phase_timer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : garage_phase_timer
// Purpose  : Loadable down-counter; done is high while the count sits at zero.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module garage_phase_timer #(
    parameter int W = 2
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] r_count;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/garage_gate_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : garage_gate_arbiter
// Purpose  : Shared one-lane gate controller: arbitrates entry/exit requests,
//            sequences door-open and guard phases, tracks occupancy.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module garage_gate_arbiter
    import garage_pkg::*;
#(
    parameter int CAPACITY     = DEF_CAPACITY,
    parameter int DOOR_CYCLES  = DEF_DOOR_CYCLES,
    parameter int GUARD_CYCLES = DEF_GUARD_CYCLES,
    parameter int CNT_W        = $clog2(CAPACITY + 1)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Car_entry_request,
    input  logic             Car_exit_request,
    output logic             Open_entry_door,
    output logic             Open_exit_door,
    output logic             Garage_is_complete,
    output logic             Garage_is_empty,
    output logic [CNT_W-1:0] Car_count
);

    localparam int TMR_MAX = (DOOR_CYCLES > GUARD_CYCLES) ? DOOR_CYCLES : GUARD_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] DOOR_LOAD  = TMR_W'(DOOR_CYCLES - 1);
    localparam logic [TMR_W-1:0] GUARD_LOAD = TMR_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(CAPACITY);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             r_pri;
    logic             w_next_pri;
    logic             r_entry_door;
    logic             r_exit_door;
    logic [CNT_W-1:0] r_count;

    logic             w_entry_ok;
    logic             w_exit_ok;
    logic             w_grant_entry;
    logic             w_grant_exit;
    logic             w_load;
    logic [TMR_W-1:0] w_load_val;
    logic             w_timer_done;

    assign Garage_is_complete = (r_count == FULL_COUNT);
    assign Garage_is_empty    = (r_count == '0);
    assign Car_count          = r_count;
    assign Open_entry_door    = r_entry_door;
    assign Open_exit_door     = r_exit_door;

    // Full/empty gating is what keeps the occupancy counter from wrapping.
    assign w_entry_ok = Car_entry_request && !Garage_is_complete;
    assign w_exit_ok  = Car_exit_request  && !Garage_is_empty;

    garage_phase_timer #(
        .W (TMR_W)
    ) u_phase_timer (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .load     (w_load),
        .load_val (w_load_val),
        .done     (w_timer_done)
    );

    always_comb begin
        w_next_state  = r_state;
        w_next_pri    = r_pri;
        w_grant_entry = 1'b0;
        w_grant_exit  = 1'b0;
        w_load        = 1'b0;
        w_load_val    = DOOR_LOAD;

        case (r_state)
            ST_IDLE: begin
                // The pointer only moves when a real tie was resolved.
                if (w_entry_ok && w_exit_ok) begin
                    if (r_pri == PRI_ENTRY) begin
                        w_grant_entry = 1'b1;
                        w_next_pri    = PRI_EXIT;
                    end else begin
                        w_grant_exit  = 1'b1;
                        w_next_pri    = PRI_ENTRY;
                    end
                end else if (w_entry_ok) begin
                    w_grant_entry = 1'b1;
                end else if (w_exit_ok) begin
                    w_grant_exit = 1'b1;
                end

                if (w_grant_entry) begin
                    w_next_state = ST_ENTRY_OPEN;
                    w_load       = 1'b1;
                end else if (w_grant_exit) begin
                    w_next_state = ST_EXIT_OPEN;
                    w_load       = 1'b1;
                end
            end
            ST_ENTRY_OPEN, ST_EXIT_OPEN: begin
                if (w_timer_done) begin
                    w_next_state = ST_GUARD;
                    w_load       = 1'b1;
                    w_load_val   = GUARD_LOAD;
                end
            end
            ST_GUARD: begin
                if (w_timer_done) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= ST_IDLE;
            r_pri        <= PRI_ENTRY;
            r_entry_door <= 1'b0;
            r_exit_door  <= 1'b0;
            r_count      <= '0;
        end else begin
            r_state      <= w_next_state;
            r_pri        <= w_next_pri;
            r_entry_door <= (w_next_state == ST_ENTRY_OPEN);
            r_exit_door  <= (w_next_state == ST_EXIT_OPEN);
            if (r_state == ST_ENTRY_OPEN && w_timer_done) begin
                r_count <= r_count + CNT_W'(1);
            end else if (r_state == ST_EXIT_OPEN && w_timer_done) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_garage_gate_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_garage_gate_arbiter
// Purpose  : Directed self-checking bench for garage_gate_arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_garage_gate_arbiter;

    localparam int CAPACITY = 8;
    localparam int CNT_W    = 4;

    logic             clk;
    logic             rst_n;
    logic             entry_req;
    logic             exit_req;
    logic             entry_door;
    logic             exit_door;
    logic             complete;
    logic             empty;
    logic [CNT_W-1:0] count;

    int n_vec;
    int n_miss;

    garage_gate_arbiter #(
        .CAPACITY     (CAPACITY),
        .DOOR_CYCLES  (4),
        .GUARD_CYCLES (2)
    ) dut (
        .Clk                (clk),
        .Reset_n            (rst_n),
        .Car_entry_request  (entry_req),
        .Car_exit_request   (exit_req),
        .Open_entry_door    (entry_door),
        .Open_exit_door     (exit_door),
        .Garage_is_complete (complete),
        .Garage_is_empty    (empty),
        .Car_count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_count(input string tag, input int exp_cnt);
        chk({tag, "_count"}, 32'(count), 32'(exp_cnt));
        chk({tag, "_full"}, 32'(complete), (exp_cnt == CAPACITY) ? 32'd1 : 32'd0);
        chk({tag, "_empty"}, 32'(empty), (exp_cnt == 0) ? 32'd1 : 32'd0);
    endtask

    // One 7-cycle transaction window starting with the request visible to the
    // next edge. Door is high on cycles 1..4; count settles by cycle 5.
    task automatic run_period(input string tag, input logic exp_en, input logic exp_ex,
                              input int exp_cnt);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk({tag, "_entry_door"}, 32'(entry_door), 32'(exp_en && c <= 4));
            chk({tag, "_exit_door"}, 32'(exit_door), 32'(exp_ex && c <= 4));
            chk({tag, "_mutex"}, 32'(entry_door & exit_door), 32'd0);
        end
        chk_count(tag, exp_cnt);
    endtask

    task automatic idle_cycles(input string tag, input int n, input int exp_cnt);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            chk({tag, "_entry_door"}, 32'(entry_door), 32'd0);
            chk({tag, "_exit_door"}, 32'(exit_door), 32'd0);
        end
        chk_count(tag, exp_cnt);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        rst_n     = 1'b0;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_entry_door", 32'(entry_door), 32'd0);
        chk("rst_exit_door", 32'(exit_door), 32'd0);
        chk_count("rst", 0);

        // Fill
        rst_n     = 1'b1;
        entry_req = 1'b1;
        for (int k = 1; k <= 8; k++) run_period("fill", 1'b1, 1'b0, k);
        idle_cycles("fill_blocked", 20, 8);

        // Drain
        entry_req = 1'b0;
        exit_req  = 1'b1;
        for (int k = 7; k >= 0; k--) run_period("drain", 1'b0, 1'b1, k);
        idle_cycles("drain_blocked", 20, 0);

        // Build up to 3, then tie: entry, exit, entry, exit
        exit_req  = 1'b0;
        entry_req = 1'b1;
        for (int k = 1; k <= 3; k++) run_period("pre_tie", 1'b1, 1'b0, k);
        exit_req = 1'b1;
        run_period("tie1", 1'b1, 1'b0, 4);
        run_period("tie2", 1'b0, 1'b1, 3);
        run_period("tie3", 1'b1, 1'b0, 4);
        run_period("tie4", 1'b0, 1'b1, 3);

        // Fill to 8, then both held while full: exit only, pointer stays ENTRY
        exit_req = 1'b0;
        for (int k = 4; k <= 8; k++) run_period("pre_full", 1'b1, 1'b0, k);
        exit_req = 1'b1;
        run_period("full_both", 1'b0, 1'b1, 7);
        entry_req = 1'b0;
        run_period("to5_a", 1'b0, 1'b1, 6);
        run_period("to5_b", 1'b0, 1'b1, 5);
        entry_req = 1'b1;
        run_period("ptr_kept", 1'b1, 1'b0, 6);
        entry_req = 1'b0;
        exit_req  = 1'b0;
        idle_cycles("settle", 3, 6);

        // Exit request at empty right after reset
        rst_n = 1'b0;
        @(negedge clk);
        chk_count("rst2", 0);
        rst_n    = 1'b1;
        exit_req = 1'b1;
        idle_cycles("empty_exit", 3, 0);
        exit_req = 1'b0;
        idle_cycles("empty_exit_after", 5, 0);

        // Reset during the second door cycle at count 2
        entry_req = 1'b1;
        run_period("mid_a", 1'b1, 1'b0, 1);
        run_period("mid_b", 1'b1, 1'b0, 2);
        @(negedge clk);
        @(negedge clk);
        chk("mid_door_before", 32'(entry_door), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_door_async", 32'(entry_door), 32'd0);
        chk("mid_count_async", 32'(count), 32'd0);
        entry_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles("post_reset", 10, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/garage_gate_arbiter.md
Name: garage_gate_arbiter

Overview:
- Controller for a single shared one-lane gate that serves both entering and leaving cars.
- Arbitrates between Car_entry_request and Car_exit_request and sequences the gate through a timed open phase and a guard phase.
- Tracks garage occupancy and drives Garage_is_complete (full) and Garage_is_empty.
- Sits between the request sensors and the door actuators at the top of the garage system.

Parameters:
- CAPACITY, 8, maximum number of cars; Garage_is_complete asserts at this count.
- DOOR_CYCLES, 4, Clk cycles a door is held open per granted transaction; legal range ≥1.
- GUARD_CYCLES, 2, Clk cycles both doors are held closed after each transaction; legal range ≥1.
- CNT_W, $clog2(CAPACITY+1), width of Car_count.

Ports:
- Clk  input  1  system clock; all state is updated on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Car_entry_request  input  1  level request; held by the requester until served.
- Car_exit_request  input  1  level request; held by the requester until served.
- Open_entry_door  output  1  entry door open command; registered.
- Open_exit_door  output  1  exit door open command; registered.
- Garage_is_complete  output  1  high when Car_count == CAPACITY.
- Garage_is_empty  output  1  high when Car_count == 0.
- Car_count  output  CNT_W  current occupancy.

Behaviour:
- Interface: one clock (Clk). Reset (Reset_n) is asynchronous and active-low.
- Reset values (while Reset_n = 0):
  - state = IDLE
  - both doors = 0
  - Car_count = 0
  - Garage_is_complete = 0, Garage_is_empty = 1
  - priority pointer = ENTRY (entry wins the first tie).
- Eligibility, evaluated in IDLE:
  - entry_ok = Car_entry_request && !Garage_is_complete
  - exit_ok = Car_exit_request && !Garage_is_empty
- FSM states: IDLE, ENTRY_OPEN, EXIT_OPEN, GUARD.
- IDLE:
  - Only entry_ok → ENTRY_OPEN.
  - Only exit_ok → EXIT_OPEN.
  - Both → the side named by the priority pointer; the pointer then flips to the other side.
  - Neither → stay in IDLE.
  - A granted request is also sampled as served.
- ENTRY_OPEN / EXIT_OPEN:
  - The corresponding door is 1 for exactly DOOR_CYCLES cycles, starting the cycle after the granting edge.
  - The timer loads DOOR_CYCLES-1 on entry and decrements each cycle.
  - On the edge where the timer reaches 0: go to GUARD. Car_count increments (entry) or decrements (exit) on that same edge, and the door drops on that edge.
- GUARD:
  - Both doors = 0 for GUARD_CYCLES cycles, then → IDLE.
  - Requests are ignored during GUARD.
- Mutual exclusion: Open_entry_door and Open_exit_door are never 1 in the same cycle.
- Latency:
  - Request present in IDLE → door high 1 cycle later.
  - A continuously held request is served every 1 + DOOR_CYCLES + GUARD_CYCLES cycles (7 with defaults).
- Requests dropped while a door is open have no effect; the transaction completes and the count still updates.
- Boundary conditions:
  - At full, entry requests are ignored and exit requests are served.
  - At empty, exit requests are ignored and entry requests are served.
  - Car_count never wraps below 0 or above CAPACITY; this is guaranteed by the eligibility gating, with no saturation logic needed.
  - If both requests are held but only one side is eligible, the eligible side is granted and the priority pointer does not change.
- Flags: Garage_is_complete and Garage_is_empty are decoded combinationally from the registered Car_count, so they update in the same cycle as Car_count.
- Reset mid-operation: the doors drop immediately (asynchronously), Car_count clears to 0, and the in-flight transaction is discarded.

Decomposition:
- Shared package garage_pkg holds:
  - the state enum (IDLE, ENTRY_OPEN, EXIT_OPEN, GUARD)
  - the priority encoding (PRI_ENTRY, PRI_EXIT)
  - default constants DEF_CAPACITY, DEF_DOOR_CYCLES, DEF_GUARD_CYCLES.
- One sub-module is natural: garage_phase_timer.
  - Loadable down-counter with ports Clk, Reset_n, load, load_val, done.
  - Used for both the door phase and the guard phase.

Test Plan:
- Fill: release reset, hold Car_entry_request = 1 only.
  - Expect Open_entry_door high for 4 cycles in a 7-cycle period.
  - Car_count steps 1..8; Garage_is_complete = 1 after the 8th door close.
  - No further Open_entry_door pulses over the next 20 cycles.
- Drain: from count 8, hold Car_exit_request only.
  - Expect 8 exit pulses; Car_count reaches 0 and Garage_is_empty = 1.
  - No ninth pulse follows.
- Tie fairness: from count 3, hold both requests for 28 cycles.
  - Expect grants in the order entry, exit, entry, exit.
  - Car_count alternates 4, 3, 4, 3.
  - The doors are never high together.
- Blocked side: at count 8 (full), hold both requests.
  - Expect only exit grants.
  - The priority pointer stays unchanged; verify this on a later tie at count 5 being resolved per the pointer.
- Exit at empty after reset: pulse Car_exit_request = 1 for 3 cycles.
  - No door opens; Car_count stays 0.
- Reset mid-door: during the 2nd cycle of Open_entry_door at count 2, drive Reset_n = 0.
  - Open_entry_door goes 0 without waiting for the next Clk edge; Car_count = 0.
  - After release with no request, the FSM stays in IDLE.
